// File: rtl/bti_demux_ot_if.sv
// BTI request and response channel interfaces shared by the host and guest ports.

interface bti_req_if_t #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TW = 8
);
  logic          vld;
  logic          rdy;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [TW-1:0] tid;

  modport mst (output vld, addr, we, wdata, tid, input rdy);
  modport slv (input vld, addr, we, wdata, tid, output rdy);
endinterface

interface bti_rsp_if_t #(
  parameter int DW = 32,
  parameter int TW = 8
);
  logic          vld;
  logic          rdy;
  logic [DW-1:0] data;
  logic          ok;
  logic [TW-1:0] tid;

  modport mst (output vld, data, ok, tid, input rdy);
  modport slv (input vld, data, ok, tid, output rdy);
endinterface

// File: rtl/bti_demux_ot.sv
// BTI address demultiplexer: one host port fanned out to GST_NUM guests with up
// to MAX_OT in-order outstanding requests and local error responses on decode miss.

module bti_demux_ot #(
  parameter int BTI_AW     = 32,
  parameter int BTI_DW     = 32,
  parameter int BTI_TW     = 8,
  parameter int GST_SEL_AW = 8,
  parameter int GST_NUM    = 4,
  parameter logic [GST_NUM-1:0][GST_SEL_AW-1:0] GST_SEL_ADDRS = '0,
  parameter logic [GST_NUM-1:0][31:0]           GST_VLD_AW    = '0,
  parameter int MAX_OT     = 4,
  localparam int CW = $clog2(MAX_OT + 1),
  localparam int IW = $clog2(GST_NUM + 1),
  localparam int PW = (MAX_OT > 1) ? $clog2(MAX_OT) : 1,
  localparam int MW = BTI_AW - GST_SEL_AW
) (
  input  logic           clk,
  input  logic           rst,
  bti_req_if_t.slv       host_bti_req_slv,
  bti_rsp_if_t.mst       host_bti_rsp_mst,
  bti_req_if_t.mst       gst_bti_req_msts [GST_NUM],
  bti_rsp_if_t.slv       gst_bti_rsp_slvs [GST_NUM],
  output logic [CW-1:0]  ot_cnt,
  output logic           dec_err
);

  logic [GST_NUM-1:0] gst_req_rdy, gst_req_vld, gst_rsp_vld, gst_rsp_rdy, gst_rsp_ok;
  logic [BTI_DW-1:0]  gst_rsp_data [GST_NUM];
  logic [BTI_TW-1:0]  gst_rsp_tid  [GST_NUM];

  logic [IW-1:0]     fifo_idx_q [MAX_OT];
  logic [IW-1:0]     fifo_idx_d [MAX_OT];
  logic [BTI_TW-1:0] fifo_tid_q [MAX_OT];
  logic [BTI_TW-1:0] fifo_tid_d [MAX_OT];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dec_err_q, dec_err_d;

  logic [IW-1:0]     sel_idx, head_idx;
  logic [BTI_TW-1:0] head_tid;
  logic              miss, sel_rdy, full, empty, push, pop, host_req_rdy;
  logic              rsp_vld, rsp_ok;
  logic [BTI_DW-1:0] rsp_data;
  logic [BTI_TW-1:0] rsp_tid;
  logic [MW-1:0]     addr_mid;

  // Guest interface arrays flattened into plain vectors for indexed access.
  for (genvar g = 0; g < GST_NUM; g++) begin : g_gst
    assign gst_req_rdy[g]             = gst_bti_req_msts[g].rdy;
    assign gst_bti_req_msts[g].vld    = gst_req_vld[g];
    assign gst_bti_req_msts[g].addr   = host_bti_req_slv.addr;
    assign gst_bti_req_msts[g].we     = host_bti_req_slv.we;
    assign gst_bti_req_msts[g].wdata  = host_bti_req_slv.wdata;
    assign gst_bti_req_msts[g].tid    = host_bti_req_slv.tid;
    assign gst_rsp_vld[g]             = gst_bti_rsp_slvs[g].vld;
    assign gst_rsp_data[g]            = gst_bti_rsp_slvs[g].data;
    assign gst_rsp_ok[g]              = gst_bti_rsp_slvs[g].ok;
    assign gst_rsp_tid[g]             = gst_bti_rsp_slvs[g].tid;
    assign gst_bti_rsp_slvs[g].rdy    = gst_rsp_rdy[g];
  end

  assign addr_mid = host_bti_req_slv.addr[MW-1:0];
  assign full     = (cnt_q == CW'(MAX_OT));
  assign empty    = (cnt_q == '0);
  assign head_idx = fifo_idx_q[rd_ptr_q];
  assign head_tid = fifo_tid_q[rd_ptr_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address decode; scanning downwards lets the lowest matching guest win.
  always_comb begin
    sel_idx = IW'(GST_NUM);
    miss    = 1'b1;
    sel_rdy = 1'b0;
    for (int i = GST_NUM - 1; i >= 0; i--) begin
      if ((host_bti_req_slv.addr[BTI_AW-1 -: GST_SEL_AW] == GST_SEL_ADDRS[i]) &&
          ((addr_mid >> GST_VLD_AW[i]) == '0)) begin
        sel_idx = IW'(i);
        miss    = 1'b0;
      end
    end
    for (int i = 0; i < GST_NUM; i++) begin
      if (sel_idx == IW'(i)) sel_rdy = gst_req_rdy[i];
    end
  end

  // Request steering; acceptance depends only on the registered count.
  always_comb begin
    host_req_rdy = ~rst & ~full & (miss | sel_rdy);
    for (int i = 0; i < GST_NUM; i++) begin
      gst_req_vld[i] = ~rst & host_bti_req_slv.vld & ~full & (sel_idx == IW'(i));
    end
    push = host_bti_req_slv.vld & host_req_rdy;
  end

  // Response selection from the route FIFO head; error responses are synthesised locally.
  always_comb begin
    rsp_vld     = 1'b0;
    rsp_data    = '0;
    rsp_ok      = 1'b0;
    rsp_tid     = '0;
    gst_rsp_rdy = '0;
    if (!rst && !empty) begin
      if (head_idx == IW'(GST_NUM)) begin
        rsp_vld = 1'b1;
        rsp_tid = head_tid;
      end else begin
        for (int i = 0; i < GST_NUM; i++) begin
          if (head_idx == IW'(i)) begin
            rsp_vld        = gst_rsp_vld[i];
            rsp_data       = gst_rsp_data[i];
            rsp_ok         = gst_rsp_ok[i];
            rsp_tid        = gst_rsp_tid[i];
            gst_rsp_rdy[i] = host_bti_rsp_mst.rdy;
          end
        end
      end
    end
    pop = rsp_vld & host_bti_rsp_mst.rdy;
  end

  // Route FIFO, pointer and outstanding-count next state.
  always_comb begin
    fifo_idx_d = fifo_idx_q;
    fifo_tid_d = fifo_tid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    dec_err_d  = push & miss;
    if (push) begin
      fifo_idx_d[wr_ptr_q] = sel_idx;
      fifo_tid_d[wr_ptr_q] = host_bti_req_slv.tid;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // Control state registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      dec_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      dec_err_q <= dec_err_d;
    end
  end

  // FIFO storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk) begin
    fifo_idx_q <= fifo_idx_d;
    fifo_tid_q <= fifo_tid_d;
  end

  assign host_bti_req_slv.rdy  = host_req_rdy;
  assign host_bti_rsp_mst.vld  = rsp_vld;
  assign host_bti_rsp_mst.data = rsp_data;
  assign host_bti_rsp_mst.ok   = rsp_ok;
  assign host_bti_rsp_mst.tid  = rsp_tid;
  assign ot_cnt                = cnt_q;
  assign dec_err               = dec_err_q;

endmodule

// File: tb/tb_bti_demux_ot.sv
// Testbench for bti_demux_ot: directed scenarios plus randomized traffic against a queue model.

module tb_bti_demux_ot;

  typedef struct { int guest; logic [7:0] tid; } exp_t;
  typedef struct { logic [7:0] tid; logic [31:0] data; logic ok; } grsp_t;

  logic clk, rst;
  logic [1:0] ot_cnt;
  logic dec_err;
  int n_tests = 0;
  int n_fail  = 0;

  logic        g_req_rdy  [2];
  logic        g_req_vld  [2];
  logic [31:0] g_req_addr [2];
  logic        g_rsp_vld  [2];
  logic        g_rsp_rdy  [2];
  logic [31:0] g_rsp_data [2];
  logic        g_rsp_ok   [2];
  logic [7:0]  g_rsp_tid  [2];

  bti_req_if_t #(.AW(32), .DW(32), .TW(8)) host_req ();
  bti_rsp_if_t #(.DW(32), .TW(8))          host_rsp ();
  bti_req_if_t #(.AW(32), .DW(32), .TW(8)) gst_req [2] ();
  bti_rsp_if_t #(.DW(32), .TW(8))          gst_rsp [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_br
    assign gst_req[g].rdy  = g_req_rdy[g];
    assign g_req_vld[g]    = gst_req[g].vld;
    assign g_req_addr[g]   = gst_req[g].addr;
    assign gst_rsp[g].vld  = g_rsp_vld[g];
    assign gst_rsp[g].data = g_rsp_data[g];
    assign gst_rsp[g].ok   = g_rsp_ok[g];
    assign gst_rsp[g].tid  = g_rsp_tid[g];
    assign g_rsp_rdy[g]    = gst_rsp[g].rdy;
  end

  bti_demux_ot #(
    .BTI_AW(32), .BTI_DW(32), .BTI_TW(8), .GST_SEL_AW(8), .GST_NUM(2),
    .GST_SEL_ADDRS({8'h10, 8'h00}), .GST_VLD_AW({32'd12, 32'd16}), .MAX_OT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .host_bti_req_slv(host_req), .host_bti_rsp_mst(host_rsp),
    .gst_bti_req_msts(gst_req), .gst_bti_rsp_slvs(gst_rsp),
    .ot_cnt(ot_cnt), .dec_err(dec_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guest index that should receive an address, 2 meaning decode miss.
  function automatic int decode(input logic [31:0] a);
    if (a[31:24] == 8'h00 && a[23:0] < 24'h010000) return 0;
    if (a[31:24] == 8'h10 && a[23:0] < 24'h001000) return 1;
    return 2;
  endfunction

  task automatic idle();
    host_req.vld = 0; host_req.addr = '0; host_req.we = 0; host_req.wdata = '0; host_req.tid = '0;
    host_rsp.rdy = 0;
    for (int g = 0; g < 2; g++) begin
      g_req_rdy[g] = 0; g_rsp_vld[g] = 0; g_rsp_data[g] = '0; g_rsp_ok[g] = 0; g_rsp_tid[g] = '0;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [7:0] t);
    @(negedge clk);
    host_req.vld = 1; host_req.addr = a; host_req.tid = t;
    g_req_rdy[0] = 1; g_req_rdy[1] = 1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    host_req.vld = 1; host_req.addr = 32'h1000_0000;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      n_tests++; if (g_req_vld[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_gvld: got %b exp 0", g_req_vld[1]); end
      n_tests++; if (ot_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_cnt: got %0d exp 0", ot_cnt); end
      n_tests++; if (host_rsp.vld !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rvld: got %b exp 0", host_rsp.vld); end
    end
    rst = 0;
    #1;
    n_tests++; if (g_req_vld[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL rel_gvld: got %b exp 1", g_req_vld[1]); end
    n_tests++; if (dec_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rel_decerr: got %b exp 0", dec_err); end
    host_req.vld = 0;
  endtask

  task automatic test_basic_hit();
    @(negedge clk);
    idle();
    host_req.vld = 1; host_req.addr = 32'h1000_0040; host_req.tid = 8'd3; g_req_rdy[1] = 1;
    #1;
    n_tests++; if (host_req.rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL hit_rdy: got %b exp 1", host_req.rdy); end
    n_tests++; if (g_req_vld[0] !== 1'b0 || g_req_vld[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL hit_gvld: got %b%b exp 10", g_req_vld[1], g_req_vld[0]); end
    n_tests++; if (g_req_addr[0] !== 32'h1000_0040) begin n_fail++; $display("[TB] FAIL hit_bcast: got %h exp 10000040", g_req_addr[0]); end
    @(negedge clk);
    host_req.vld = 0;
    n_tests++; if (ot_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL hit_cnt1: got %0d exp 1", ot_cnt); end
    g_rsp_vld[1] = 1; g_rsp_tid[1] = 8'd3; g_rsp_data[1] = 32'hDEADBEEF; g_rsp_ok[1] = 1; host_rsp.rdy = 1;
    #1;
    n_tests++; if ({host_rsp.vld, host_rsp.tid, host_rsp.data, host_rsp.ok} !== {1'b1, 8'd3, 32'hDEADBEEF, 1'b1}) begin
      n_fail++; $display("[TB] FAIL hit_rsp: got v%b t%0d d%h ok%b exp v1 t3 dDEADBEEF ok1", host_rsp.vld, host_rsp.tid, host_rsp.data, host_rsp.ok); end
    n_tests++; if (g_rsp_rdy[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL hit_grdy: got %b exp 1", g_rsp_rdy[1]); end
    @(negedge clk);
    idle();
    n_tests++; if (ot_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL hit_cnt0: got %0d exp 0", ot_cnt); end
  endtask

  task automatic test_decode_miss();
    @(negedge clk);
    idle();
    host_req.vld = 1; host_req.addr = 32'h1000_1000; host_req.tid = 8'd5;
    #1;
    n_tests++; if (host_req.rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL miss_rdy: got %b exp 1", host_req.rdy); end
    n_tests++; if (g_req_vld[0] !== 1'b0 || g_req_vld[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_gvld: got %b%b exp 00", g_req_vld[1], g_req_vld[0]); end
    n_tests++; if (host_rsp.vld !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_early: got %b exp 0", host_rsp.vld); end
    @(negedge clk);
    host_req.vld = 0;
    #1;
    n_tests++; if (dec_err !== 1'b1) begin n_fail++; $display("[TB] FAIL miss_decerr: got %b exp 1", dec_err); end
    n_tests++; if ({host_rsp.vld, host_rsp.tid, host_rsp.data, host_rsp.ok} !== {1'b1, 8'd5, 32'h0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL miss_rsp: got v%b t%0d d%h ok%b exp v1 t5 d0 ok0", host_rsp.vld, host_rsp.tid, host_rsp.data, host_rsp.ok); end
    @(negedge clk);
    n_tests++; if (dec_err !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_pulse: got %b exp 0", dec_err); end
    n_tests++; if (host_rsp.vld !== 1'b1) begin n_fail++; $display("[TB] FAIL miss_hold: got %b exp 1", host_rsp.vld); end
    host_rsp.rdy = 1;
    @(negedge clk);
    host_rsp.rdy = 0;
    #1;
    n_tests++; if (ot_cnt !== 2'd0 || host_rsp.vld !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_pop: got cnt %0d vld %b exp 0 0", ot_cnt, host_rsp.vld); end
  endtask

  task automatic test_ordering();
    idle();
    send(32'h1000_0000, 8'd1);
    send(32'h0000_0100, 8'd2);
    @(negedge clk);
    idle();
    g_rsp_vld[0] = 1; g_rsp_tid[0] = 8'd2; g_rsp_data[0] = 32'h22; g_rsp_ok[0] = 1; host_rsp.rdy = 1;
    #1;
    n_tests++; if (g_rsp_rdy[0] !== 1'b0 || host_rsp.vld !== 1'b0) begin n_fail++; $display("[TB] FAIL ord_block: got rdy0 %b hvld %b exp 0 0", g_rsp_rdy[0], host_rsp.vld); end
    @(negedge clk);
    n_tests++; if (g_rsp_rdy[0] !== 1'b0 || ot_cnt !== 2'd2) begin n_fail++; $display("[TB] FAIL ord_wait: got rdy0 %b cnt %0d exp 0 2", g_rsp_rdy[0], ot_cnt); end
    g_rsp_vld[1] = 1; g_rsp_tid[1] = 8'd1; g_rsp_data[1] = 32'h11; g_rsp_ok[1] = 1;
    #1;
    n_tests++; if (host_rsp.tid !== 8'd1 || host_rsp.data !== 32'h11 || g_rsp_rdy[1] !== 1'b1 || g_rsp_rdy[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ord_first: got t%0d d%h r1 %b r0 %b exp t1 d11 r1 1 r0 0", host_rsp.tid, host_rsp.data, g_rsp_rdy[1], g_rsp_rdy[0]); end
    @(negedge clk);
    g_rsp_vld[1] = 0;
    #1;
    n_tests++; if (host_rsp.vld !== 1'b1 || host_rsp.tid !== 8'd2 || g_rsp_rdy[0] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ord_second: got v%b t%0d r0 %b exp v1 t2 r0 1", host_rsp.vld, host_rsp.tid, g_rsp_rdy[0]); end
    @(negedge clk);
    idle();
    n_tests++; if (ot_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL ord_drain: got %0d exp 0", ot_cnt); end
  endtask

  task automatic test_full();
    idle();
    send(32'h0000_0010, 8'd7);
    send(32'h0000_0010, 8'd8);
    @(negedge clk);
    host_req.tid = 8'd9;
    #1;
    n_tests++; if (host_req.rdy !== 1'b0 || g_req_vld[0] !== 1'b0 || g_req_vld[1] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL full_block: got rdy %b gv %b%b exp 0 00", host_req.rdy, g_req_vld[1], g_req_vld[0]); end
    n_tests++; if (ot_cnt !== 2'd2) begin n_fail++; $display("[TB] FAIL full_cnt2: got %0d exp 2", ot_cnt); end
    @(negedge clk);
    g_rsp_vld[0] = 1; g_rsp_tid[0] = 8'd7; g_rsp_data[0] = 32'h7; g_rsp_ok[0] = 1; host_rsp.rdy = 1;
    #1;
    n_tests++; if (host_req.rdy !== 1'b0 || host_rsp.vld !== 1'b1) begin n_fail++; $display("[TB] FAIL full_popcyc: got rdy %b rvld %b exp 0 1", host_req.rdy, host_rsp.vld); end
    @(negedge clk);
    g_rsp_vld[0] = 0; host_rsp.rdy = 0;
    #1;
    n_tests++; if (ot_cnt !== 2'd1 || host_req.rdy !== 1'b1 || g_req_vld[0] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL full_cnt1: got cnt %0d rdy %b gv0 %b exp 1 1 1", ot_cnt, host_req.rdy, g_req_vld[0]); end
    @(negedge clk);
    host_req.vld = 0;
    n_tests++; if (ot_cnt !== 2'd2) begin n_fail++; $display("[TB] FAIL full_refill: got %0d exp 2", ot_cnt); end
    g_rsp_vld[0] = 1; g_rsp_tid[0] = 8'd8; host_rsp.rdy = 1;
    @(negedge clk);
    g_rsp_tid[0] = 8'd9;
    #1;
    n_tests++; if (host_rsp.tid !== 8'd9 || ot_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL full_third: got t%0d cnt %0d exp t9 1", host_rsp.tid, ot_cnt); end
    @(negedge clk);
    idle();
    n_tests++; if (ot_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL full_drain: got %0d exp 0", ot_cnt); end
  endtask

  task automatic test_reset_mid();
    idle();
    send(32'h1000_0000, 8'd1);
    send(32'h0000_0000, 8'd2);
    @(negedge clk);
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    n_tests++; if (ot_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL rmid_cnt: got %0d exp 0", ot_cnt); end
    g_rsp_vld[1] = 1; g_rsp_tid[1] = 8'd1; host_rsp.rdy = 1;
    #1;
    n_tests++; if (g_rsp_rdy[1] !== 1'b0 || host_rsp.vld !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_late: got rdy %b vld %b exp 0 0", g_rsp_rdy[1], host_rsp.vld); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_random();
    exp_t  exp_q [$];
    grsp_t gq0 [$];
    grsp_t gq1 [$];
    logic exp_dec = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int sel, h;
      logic full, e_hrdy, e_rvld, e_rok, push, pop;
      logic [7:0]  e_rtid;
      logic [31:0] e_rdata, a;
      logic [1:0]  e_grdy;
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: a = {8'h00, 8'h00, 16'($urandom)};
        1: a = {8'h10, 12'h000, 12'($urandom)};
        2: a = {8'h10, 24'($urandom) | 24'h001000};
        default: a = $urandom;
      endcase
      host_req.vld = ($urandom_range(0, 2) != 0); host_req.addr = a; host_req.tid = 8'($urandom);
      g_req_rdy[0] = $urandom_range(0, 1); g_req_rdy[1] = $urandom_range(0, 1);
      host_rsp.rdy = ($urandom_range(0, 2) != 0);
      g_rsp_vld[0] = (gq0.size() > 0) && ($urandom_range(0, 2) != 0);
      g_rsp_vld[1] = (gq1.size() > 0) && ($urandom_range(0, 2) != 0);
      if (gq0.size() > 0) begin g_rsp_tid[0] = gq0[0].tid; g_rsp_data[0] = gq0[0].data; g_rsp_ok[0] = gq0[0].ok; end
      if (gq1.size() > 0) begin g_rsp_tid[1] = gq1[0].tid; g_rsp_data[1] = gq1[0].data; g_rsp_ok[1] = gq1[0].ok; end
      #1;
      sel    = decode(a);
      full   = (exp_q.size() == 2);
      e_hrdy = !full && (sel == 2 || g_req_rdy[sel]);
      e_rvld = 0; e_rtid = '0; e_rdata = '0; e_rok = 0; e_grdy = 2'b00; h = 3;
      if (exp_q.size() > 0) begin
        h = exp_q[0].guest;
        if (h == 2) begin e_rvld = 1; e_rtid = exp_q[0].tid; end
        else begin
          e_rvld = g_rsp_vld[h]; e_rtid = exp_q[0].tid;
          e_rdata = (h == 0) ? gq0[0].data : gq1[0].data;
          e_rok   = (h == 0) ? gq0[0].ok : gq1[0].ok;
          e_grdy[h] = host_rsp.rdy;
        end
      end
      n_tests++; if (ot_cnt !== 2'(exp_q.size())) begin n_fail++; $display("[TB] FAIL rnd_cnt@%0d: got %0d exp %0d", cyc, ot_cnt, exp_q.size()); end
      n_tests++; if (host_req.rdy !== e_hrdy) begin n_fail++; $display("[TB] FAIL rnd_hrdy@%0d: got %b exp %b", cyc, host_req.rdy, e_hrdy); end
      for (int g = 0; g < 2; g++) begin
        n_tests++; if (g_req_vld[g] !== (host_req.vld && sel == g && !full)) begin
          n_fail++; $display("[TB] FAIL rnd_gvld%0d@%0d: got %b exp %b", g, cyc, g_req_vld[g], host_req.vld && sel == g && !full); end
        n_tests++; if (g_rsp_rdy[g] !== e_grdy[g]) begin n_fail++; $display("[TB] FAIL rnd_grdy%0d@%0d: got %b exp %b", g, cyc, g_rsp_rdy[g], e_grdy[g]); end
      end
      n_tests++; if (host_rsp.vld !== e_rvld) begin n_fail++; $display("[TB] FAIL rnd_rvld@%0d: got %b exp %b", cyc, host_rsp.vld, e_rvld); end
      if (e_rvld) begin
        n_tests++; if ({host_rsp.tid, host_rsp.data, host_rsp.ok} !== {e_rtid, e_rdata, e_rok}) begin
          n_fail++; $display("[TB] FAIL rnd_rpkt@%0d: got t%0d d%h ok%b exp t%0d d%h ok%b", cyc, host_rsp.tid, host_rsp.data, host_rsp.ok, e_rtid, e_rdata, e_rok); end
      end
      n_tests++; if (dec_err !== exp_dec) begin n_fail++; $display("[TB] FAIL rnd_decerr@%0d: got %b exp %b", cyc, dec_err, exp_dec); end
      push = host_req.vld && e_hrdy;
      pop  = e_rvld && host_rsp.rdy;
      if (pop) begin
        if (h == 0) void'(gq0.pop_front());
        if (h == 1) void'(gq1.pop_front());
        void'(exp_q.pop_front());
      end
      if (push) begin
        exp_q.push_back('{guest: sel, tid: host_req.tid});
        if (sel == 0) gq0.push_back('{tid: host_req.tid, data: $urandom, ok: 1'($urandom)});
        if (sel == 1) gq1.push_back('{tid: host_req.tid, data: $urandom, ok: 1'($urandom)});
      end
      exp_dec = push && (sel == 2);
    end
    @(negedge clk);
    idle();
  endtask

  // Scenario sequence and final summary.
  initial begin
    rst = 1;
    idle();
    test_reset();
    test_basic_hit();
    test_decode_miss();
    test_ordering();
    test_full();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
